// File: rtl/ysyx_23060203_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_pkg
// Shared types and constants for the fetch unit with the decoupling queue.
//   fq_entry_t   : one queued instruction {pc, inst, pnpc}
//   perf_t       : one-cycle perf event strobes exported by the IFU
//   PRED_*       : prediction mode selectors
//   OP_*         : opcode[6:2] values recognised by the static predictor
//   imm_b/imm_j  : RV32 B/J immediate decoders
//   predict_pnpc : predicted next PC for a fetched word
// ---------------------------------------------------------------------------
package ysyx_23060203_ifu_pkg;

    localparam int PRED_NONE   = 0;
    localparam int PRED_STATIC = 1;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pnpc;
    } fq_entry_t;

    typedef struct packed {
        logic ifu_hold;    // head entry is being offered to IDU
        logic ifu_wait;    // nothing to offer to IDU
        logic fetch_hold;  // ICache delivered data this cycle
        logic fetch_wait;  // ICache refill in progress
        logic ifu_inst;    // an instruction left the queue
        logic fq_full;     // queue occupancy is at DEPTH
    } perf_t;

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Static prediction: backward conditional branches and JAL are taken,
    // everything else falls through. PRED_NONE always falls through.
    function automatic logic [31:0] predict_pnpc(input logic [31:0] pc,
                                                 input logic [31:0] inst,
                                                 input int          mode);
        logic [31:0] pnpc;
        pnpc = pc + 32'd4;
        if (mode == PRED_STATIC) begin
            if ((inst[6:2] == OP_BRANCH) && inst[31]) begin
                pnpc = pc + imm_b(inst);
            end else if (inst[6:2] == OP_JAL) begin
                pnpc = pc + imm_j(inst);
            end
        end
        return pnpc;
    endfunction

endpackage

// File: rtl/ysyx_23060203_ifu_fq_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_fq_if
// Bundles the two IFU-facing channels:
//   ICache lookup : fetch_addr (IFU->cache), fetch_hit / fetch_inst (cache->IFU)
//   IDU output    : out_valid / out_pc / out_inst / out_pnpc (IFU->IDU),
//                   out_ready (IDU->IFU)
//   perf          : event strobes from the IFU
// Handshake: an entry transfers to IDU in a cycle where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and the
// out_* payload is stable while out_valid is high and out_ready is low.
// On the cache side fetch_addr stays stable while fetch_hit is low.
// Modports: master = IFU side, slave = ICache/IDU environment side.
// ---------------------------------------------------------------------------
interface ysyx_23060203_ifu_fq_if;
    import ysyx_23060203_ifu_pkg::*;

    logic [31:0] fetch_addr;
    logic        fetch_hit;
    logic [31:0] fetch_inst;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_pnpc;

    perf_t       perf;

    modport master (
        output fetch_addr,
        input  fetch_hit,
        input  fetch_inst,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output out_pnpc,
        output perf
    );

    modport slave (
        input  fetch_addr,
        output fetch_hit,
        output fetch_inst,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  out_pnpc,
        input  perf
    );

endinterface

// File: rtl/ysyx_23060203_ifu_queue.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_queue
// Synchronous FIFO of fq_entry_t with DEPTH entries (power of two, >= 2).
//   clock, reset : clock and synchronous active-high reset
//   push         : write push_data at the tail (accepted when not full or
//                  when a pop happens in the same cycle)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the queue on the next edge; wins over push/pop
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
//   head         : head entry, combinational from the storage array
// Entry storage is not reset; only pointers and count are.
// ---------------------------------------------------------------------------
module ysyx_23060203_ifu_queue
    import ysyx_23060203_ifu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fq_entry_t     head
);

    fq_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves in the
    // same cycle; popping an empty queue is a no-op.
    assign push_ok = push & (~full | pop_ok);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly PW bits wide, so they wrap modulo DEPTH.
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ysyx_23060203_ifu_fq.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_ifu_fq
// Instruction fetch unit decoupled from decode by a DEPTH-entry queue.
// Every queued instruction carries its predicted next PC so EXU can detect
// mispredicts.
//   clock, reset        : clock and synchronous active-high reset
//   bus (master)        : ICache lookup channel, IDU output channel, perf
//   jump_flush/jump_dnpc: EXU redirect
//   cs_flush/cs_dnpc    : trap/mret redirect, wins over jump_flush
//   fq_count            : queue occupancy (debug/perf)
// A redirect that arrives while the cache is refilling is remembered in
// flush_r/dnpc_r: fetch_addr must stay stable until the hit, and that hit
// (which belongs to the stale address) is thrown away.
// ---------------------------------------------------------------------------
module ysyx_23060203_ifu_fq
    import ysyx_23060203_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          DEPTH     = 4,
    parameter int          PRED_MODE = PRED_STATIC
) (
    input  logic                         clock,
    input  logic                         reset,
    ysyx_23060203_ifu_fq_if.master       bus,
    input  logic                         jump_flush,
    input  logic [31:0]                  jump_dnpc,
    input  logic                         cs_flush,
    input  logic [31:0]                  cs_dnpc,
    output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        flush_r_q,    flush_r_d;
    logic [31:0] dnpc_r_q,     dnpc_r_d;

    logic        flush;
    logic        flush_w;
    logic [31:0] dnpc;
    logic [31:0] pnpc;
    logic        enq;
    logic        deq;
    logic        out_valid;
    logic        fq_full;
    logic        fq_empty;
    fq_entry_t   enq_entry;
    fq_entry_t   head;
    perf_t       perf;

    // ---------------- redirect and prediction ----------------
    assign flush   = cs_flush | jump_flush;
    assign dnpc    = cs_flush ? cs_dnpc : jump_dnpc;
    assign flush_w = flush | flush_r_q;
    assign pnpc    = predict_pnpc(fetch_addr_q, bus.fetch_inst, PRED_MODE);

    // ---------------- queue handshake ----------------
    // out_valid is masked by a same-cycle flush, so deq and flush never
    // coincide; enq is blocked by any live or pending redirect.
    assign out_valid = ~fq_empty & ~flush;
    assign deq       = out_valid & bus.out_ready;
    assign enq       = bus.fetch_hit & ~flush_w & (~fq_full | deq);

    assign enq_entry = '{pc: fetch_addr_q, inst: bus.fetch_inst, pnpc: pnpc};

    ysyx_23060203_ifu_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (enq),
        .push_data (enq_entry),
        .pop       (deq),
        .flush     (flush),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count),
        .head      (head)
    );

    // ---------------- fetch address / pending redirect ----------------
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (!bus.fetch_hit) begin
            fetch_addr_d = fetch_addr_q;   // refill in progress: hold
        end else if (flush) begin
            fetch_addr_d = dnpc;
        end else if (flush_r_q) begin
            fetch_addr_d = dnpc_r_q;       // completing hit is discarded
        end else if (enq) begin
            fetch_addr_d = pnpc;
        end

        flush_r_d = flush_w & ~bus.fetch_hit;
        dnpc_r_d  = flush ? dnpc : dnpc_r_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_addr_q <= RESET_PC;
            flush_r_q    <= 1'b0;
            dnpc_r_q     <= RESET_PC;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            flush_r_q    <= flush_r_d;
            dnpc_r_q     <= dnpc_r_d;
        end
    end

    // ---------------- perf strobes ----------------
    always_comb begin
        perf = '0;
        if (!reset) begin
            perf.ifu_hold   = out_valid;
            perf.ifu_wait   = ~out_valid;
            perf.fetch_hold = bus.fetch_hit;
            perf.fetch_wait = ~bus.fetch_hit;
            perf.ifu_inst   = deq;
            perf.fq_full    = fq_full;
        end
    end

    // ---------------- outputs ----------------
    assign bus.fetch_addr = fetch_addr_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = head.pc;
    assign bus.out_inst   = head.inst;
    assign bus.out_pnpc   = head.pnpc;
    assign bus.perf       = perf;

endmodule

// File: doc/ysyx_23060203_ifu_fq.md
Name: ysyx_23060203_ifu_fq

Overview:
Second-generation instruction fetch unit. It decouples instruction-cache fetch from decode with a parametrised fetch queue, so fetch keeps running while the backend stalls. Prediction mode is selectable, and every queued instruction carries its predicted next PC so EXU can detect mispredicts. It sits between the external ICache (combinational hit/inst lookup on fetch_addr) and IDU.

Parameters:
RESET_PC, 32'h80000000, first fetch address (SoC build uses 32'h30000000)
DEPTH, 4, fetch-queue entries; power of two, >= 2
PRED_MODE, 1, 0 = always pc+4; 1 = static prediction (backward branch taken, JAL taken)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fetch_addr  out  32  address presented to ICache; must stay stable while fetch_hit = 0
fetch_hit  in  1  ICache has valid data for fetch_addr this cycle
fetch_inst  in  32  instruction word for fetch_addr, valid when fetch_hit = 1
jump_flush  in  1  EXU redirect
jump_dnpc  in  32  EXU redirect target
cs_flush  in  1  control/status redirect (trap/mret); takes priority over jump_flush
cs_dnpc  in  32  control/status redirect target
out_ready  in  1  IDU accepts the head entry
out_valid  out  1  head entry valid
out_pc  out  32  head entry PC
out_inst  out  32  head entry instruction
out_pnpc  out  32  head entry predicted next PC
fq_count  out  $clog2(DEPTH+1)  queue occupancy, for debug and perf

Behaviour:
- Reset (synchronous, active-high):
  - fetch_addr = RESET_PC.
  - Queue empty: pointers 0, fq_count 0, out_valid 0.
  - flush_r = 0.
  - Entry data registers are not reset.
- Signal definitions:
  - flush = cs_flush | jump_flush.
  - dnpc = cs_flush ? cs_dnpc : jump_dnpc.
  - flush_w = flush | flush_r.
- Prediction from fetch_inst:
  - opcode[6:2] = 11000 with inst[31] = 1: pnpc = pc + imm_b.
  - opcode[6:2] = 11011: pnpc = pc + imm_j.
  - All other instructions: pnpc = pc + 4.
  - PRED_MODE = 0: pnpc is always pc + 4.
  - All additions are 32-bit modulo; no overflow detection.
- Enqueue:
  - enq = fetch_hit & ~flush_w & (~full | deq).
  - Written entry = {fetch_addr, fetch_inst, pnpc}.
- Dequeue:
  - deq = out_valid & out_ready.
  - out_valid = ~empty & ~flush.
  - out_* are driven from the head entry combinationally.
- Latency: a hit into an empty queue becomes visible at out_valid in the next cycle; there is no bypass.
- fetch_addr next-state, in priority order:
  - ~fetch_hit: hold (ICache refill in progress).
  - flush: dnpc.
  - flush_r: dnpc_r.
  - enq: pnpc.
  - Otherwise: hold.
- Pending flush:
  - flush_r_next = flush_w & ~fetch_hit.
  - dnpc_r captures dnpc on any flush; the latest flush wins.
  - The hit that completes a pending redirect is discarded and not enqueued.
- Flush:
  - Clears the queue next cycle (pointers and count to 0).
  - Suppresses out_valid in the same cycle.
  - A deq coinciding with a flush cannot occur, because out_valid is low.
- Full and empty cases:
  - Full with no deq: enq = 0 and fetch_addr holds.
  - Full with deq in the same cycle: enq and deq both occur and the count is unchanged.
  - Empty: out_valid = 0 regardless of out_ready.
- Pointers: $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- fq_count: +1 on enq only, -1 on deq only, unchanged on both; never exceeds DEPTH.
- Reset mid-operation: discards the queue and any pending flush; the next fetch is RESET_PC.
- Non-synthesis perf events, emitted when not in reset:
  - PERF_IFU_HOLD or PERF_IFU_WAIT, by out_valid.
  - PERF_IFU_FETCH_HOLD or PERF_IFU_FETCH_WAIT, by fetch_hit.
  - PERF_IFU_INST on deq.
  - PERF_IFU_FQ_FULL when full.

Decomposition:
- Package ysyx_23060203_ifu_pkg contains:
  - fq_entry_t struct {pc, inst, pnpc}.
  - PRED_NONE = 0 and PRED_STATIC = 1.
  - OP_BRANCH = 5'b11000 and OP_JAL = 5'b11011.
- One sub-module, ysyx_23060203_ifu_queue:
  - Generic synchronous FIFO of fq_entry_t, parametrised by DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - The prediction and fetch-PC logic stay in the top module.

Test Plan:
1. DEPTH = 4, fetch_hit = 1, all instructions 0x00000013, out_ready = 0 -> four entries at 0x80000000..0x8000000C; fq_count = 4; fetch_addr holds 0x80000010; out_pc = 0x80000000, out_pnpc = 0x80000004.
2. 0xFE000CE3 (beq -8) at 0x80000008, PRED_MODE = 1 -> next fetch_addr 0x80000000, entry pnpc 0x80000000. Same stimulus with PRED_MODE = 0 -> fetch_addr 0x8000000C.
3. 0x0100006F (jal +16) at 0x80000004 -> next fetch_addr 0x80000014, entry pnpc 0x80000014.
4. fetch_hit = 0 and jump_flush with jump_dnpc = 0x80000100 -> fetch_addr holds and out_valid = 0 in the same cycle; queue empty next cycle; on the later hit, that data is dropped and the next fetch_addr is 0x80000100.
5. cs_flush (0x80000200) and jump_flush (0x80000100) in the same cycle while fetch_hit = 1 -> next fetch_addr 0x80000200; queue empty.
6. Queue full, out_ready = 1, fetch_hit = 1 -> fq_count stays 4; head advances by one entry; new tail PC = previous fetch_addr; pointers wrap past index 3 correctly.
